// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall/flush/forwarding control for a 5-stage RV32I pipeline,
//                with a data-memory wait sequencer (timeout) and perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultsrcE,
  input  logic             PCsrcE,
  input  logic [4:0]       RdM,
  input  logic             regWriteM,
  input  logic             MemWriteM,
  input  logic [1:0]       ResultsrcM,
  input  logic [4:0]       RdW,
  input  logic             regWriteW,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] c_timeout = WC_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [WC_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic w_memacc, w_lwstall, w_timeout, w_memwait, w_set_err;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    if (wr_m && (rd_m == rs) && (rd_m != 5'd0))
      return 2'b10;
    else if (wr_w && (rd_w == rs) && (rd_w != 5'd0))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign w_memacc  = MemWriteM | (ResultsrcM == 2'b01);
  assign w_lwstall = (ResultsrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_timeout = (r_state == S_MEM_WAIT) && (r_wait_cnt == c_timeout);
  // The timeout cycle releases the pipeline even though memory is still busy.
  assign w_memwait = w_memacc && !dmem_ready && !w_timeout;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_set_err      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_memacc && !dmem_ready) begin
          w_state_nxt    = S_MEM_WAIT;
          w_wait_cnt_nxt = WC_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
        end else if (w_timeout) begin
          w_state_nxt    = S_RUN;
          w_wait_cnt_nxt = '0;
          w_set_err      = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
        end
      end
      default: begin
        w_state_nxt    = S_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RdM, regWriteM, RdW, regWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, regWriteM, RdW, regWriteW);
      // EX is frozen during a memory wait, so a taken branch is acted on after release.
      if (w_memwait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCsrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_lwstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_set_err)
        r_mem_err <= 1'b1;
      if (StallF)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (FlushE)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed and randomized self-checking bench for hazard_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultsrcE, ResultsrcM;
  logic        PCsrcE, regWriteM, MemWriteM, regWriteW, dmem_ready;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: cycles spent waiting on the current access, error, counters.
  int          m_waited = 0;
  logic        m_err    = 1'b0;
  logic [31:0] m_sc     = '0;
  logic [31:0] m_fc     = '0;
  logic        e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
  logic [1:0]  e_fa, e_fb;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultsrcE(ResultsrcE), .PCsrcE(PCsrcE), .RdM(RdM), .regWriteM(regWriteM),
    .MemWriteM(MemWriteM), .ResultsrcM(ResultsrcM), .RdW(RdW), .regWriteW(regWriteW),
    .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (regWriteM && rs != 0 && RdM == rs) return 2'b10;
    if (regWriteW && rs != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    reset = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultsrcE = 0; ResultsrcM = 0; PCsrcE = 0; regWriteM = 0; MemWriteM = 0;
    regWriteW = 0; dmem_ready = 1;
  endtask

  // Wait to the falling edge, derive expectations from the rules, compare all outputs.
  task automatic cyc_check();
    logic memacc, lw, mw;
    @(negedge clk);
    memacc = MemWriteM || (ResultsrcM == 2'b01);
    lw = (ResultsrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    mw = memacc && !dmem_ready && (m_waited != TO);
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
    e_fa = 2'b00; e_fb = 2'b00;
    if (reset) begin
      {e_fd, e_fe, e_fw} = 3'b111;
    end else begin
      e_fa = ref_fwd(Rs1E);
      e_fb = ref_fwd(Rs2E);
      if (mw)          {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
      else if (PCsrcE) {e_fd, e_fe} = 2'b11;
      else if (lw)     {e_sf, e_sd, e_fe} = 3'b111;
    end
    chk("StallF", StallF, e_sf);  chk("StallD", StallD, e_sd);
    chk("StallE", StallE, e_se);  chk("StallM", StallM, e_sm);
    chk("FlushD", FlushD, e_fd);  chk("FlushE", FlushE, e_fe);
    chk("FlushW", FlushW, e_fw);
    chk("ForwardAE", ForwardAE, e_fa); chk("ForwardBE", ForwardBE, e_fb);
    chk("mem_err", mem_err, m_err);
    chk("stall_cnt", stall_cnt, m_sc); chk("flush_cnt", flush_cnt, m_fc);
  endtask

  // Advance the model by one clock, then move to just past the rising edge.
  task automatic cyc_end();
    if (reset) begin
      m_waited = 0; m_err = 0; m_sc = '0; m_fc = '0;
    end else begin
      if (e_sf) m_sc = m_sc + 1;
      if (e_fe) m_fc = m_fc + 1;
      if (m_waited == 0) begin
        if ((MemWriteM || ResultsrcM == 2'b01) && !dmem_ready) m_waited = 1;
      end else if (dmem_ready) begin
        m_waited = 0;
      end else if (m_waited == TO) begin
        m_waited = 0; m_err = 1;
      end else begin
        m_waited++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1;
    cyc_check(); cyc_end();
    reset = 0;
  endtask

  initial begin
    idle(); reset = 1;
    @(posedge clk); #1;

    // Reset state
    cyc_check();
    chk("rst_FlushD", FlushD, 1); chk("rst_StallF", StallF, 0); chk("rst_cnt", stall_cnt, 0);
    cyc_end();
    reset = 0;

    // 1: forwarding, MEM priority over WB, x0 never forwarded
    idle(); RdM = 5; regWriteM = 1; RdW = 5; regWriteW = 1; Rs1E = 5;
    cyc_check(); chk("t1_fwdA_mem", ForwardAE, 2'b10); cyc_end();
    idle(); RdM = 0; regWriteM = 1; Rs1E = 0;
    cyc_check(); chk("t1_fwdA_x0", ForwardAE, 2'b00); cyc_end();
    idle(); RdW = 7; regWriteW = 1; Rs2E = 7;
    cyc_check(); chk("t1_fwdB_wb", ForwardBE, 2'b01); cyc_end();

    // 2: load-use bubble
    do_reset();
    idle(); ResultsrcE = 2'b01; RdE = 6; Rs2D = 6;
    cyc_check(); chk("t2_stallD", StallD, 1); chk("t2_flushE", FlushE, 1); cyc_end();
    idle();
    cyc_check(); chk("t2_stall_cnt", stall_cnt, 1); chk("t2_flush_cnt", flush_cnt, 1); cyc_end();

    // 3: taken branch overrides load-use
    idle(); ResultsrcE = 2'b01; RdE = 6; Rs1D = 6; PCsrcE = 1;
    cyc_check(); chk("t3_flushD", FlushD, 1); chk("t3_stallF", StallF, 0); cyc_end();

    // 4: three-cycle memory wait; a pending branch is held until release
    do_reset();
    idle(); ResultsrcM = 2'b01; dmem_ready = 0; PCsrcE = 1;
    for (int i = 0; i < 3; i++) begin
      cyc_check(); chk("t4_stallM", StallM, 1); chk("t4_flushW", FlushW, 1);
      chk("t4_flushD", FlushD, 0); cyc_end();
    end
    dmem_ready = 1;
    cyc_check(); chk("t4_rel_stallF", StallF, 0); chk("t4_rel_flushD", FlushD, 1); cyc_end();
    idle();
    cyc_check(); chk("t4_mem_err", mem_err, 0); chk("t4_stall_cnt", stall_cnt, 3); cyc_end();

    // 5: timeout
    idle(); MemWriteM = 1; dmem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      cyc_check(); chk("t5_stall", StallF, 1); cyc_end();
    end
    cyc_check(); chk("t5_to_stallF", StallF, 0); chk("t5_to_err_pre", mem_err, 0); cyc_end();
    idle();
    for (int i = 0; i < 3; i++) begin
      cyc_check(); chk("t5_err_sticky", mem_err, 1); cyc_end();
    end

    // 6: reset in the middle of a wait
    idle(); MemWriteM = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) begin cyc_check(); cyc_end(); end
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      cyc_check(); chk("t6_rst_flushW", FlushW, 1); chk("t6_rst_stallF", StallF, 0); cyc_end();
    end
    reset = 0;
    cyc_check(); chk("t6_cnt0", stall_cnt, 0); chk("t6_err0", mem_err, 0); cyc_end();
    for (int i = 1; i < TO; i++) begin cyc_check(); cyc_end(); end
    cyc_check(); chk("t6_fresh_timeout", StallF, 0); cyc_end();

    // Randomized traffic with occasional resets and long memory stalls
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      ResultsrcE = 2'($urandom_range(0, 2));
      ResultsrcM = 2'($urandom_range(0, 2));
      PCsrcE     = ($urandom_range(0, 5) == 0);
      regWriteM  = 1'($urandom_range(0, 1));
      regWriteW  = 1'($urandom_range(0, 1));
      MemWriteM  = ($urandom_range(0, 3) == 0);
      dmem_ready = ((i % 400) >= 370) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if ((i % 400) >= 370) reset = 0;
      cyc_check(); cyc_end();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
